// File: rtl/risc_spm_pkg.sv
// rtl/risc_spm_pkg.sv - shared RISC_SPM sizes and dump FSM state encoding
package risc_spm_pkg;
  localparam int WORD_SIZE = 8;
  localparam int ADDR_SIZE = 8;
  localparam int MEM_DEPTH = 2 ** ADDR_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } dump_state_t;
endpackage

// File: rtl/mem_dump_unit_if.sv
// rtl/mem_dump_unit_if.sv - control, memory read port and beat stream of the dump unit
interface mem_dump_unit_if #(
  parameter int word_size = 8,
  parameter int addr_size = 8
);
  logic                 start;
  logic [addr_size-1:0] first_addr;
  logic [addr_size-1:0] last_addr;
  logic                 busy;
  logic                 done;
  logic                 cpu_hold;
  logic [addr_size-1:0] mem_rd_addr;
  logic [word_size-1:0] mem_rd_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [addr_size-1:0] out_addr;
  logic [word_size-1:0] out_data;
  logic                 out_last;

  modport master (
    output start, first_addr, last_addr, mem_rd_data, out_ready,
    input  busy, done, cpu_hold, mem_rd_addr, out_valid, out_addr, out_data, out_last
  );

  modport slave (
    input  start, first_addr, last_addr, mem_rd_data, out_ready,
    output busy, done, cpu_hold, mem_rd_addr, out_valid, out_addr, out_data, out_last
  );
endinterface

// File: rtl/mem_dump_unit.sv
// rtl/mem_dump_unit.sv - streams a wrapping memory range as (address, data) beats
// Optional DUMP_CHECKSUM_EN appends a beat carrying the running sum of the data words.
module mem_dump_unit
  import risc_spm_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int addr_size = ADDR_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  mem_dump_unit_if.slave  bus
);
  localparam logic [addr_size:0]   CNT_ONE = (addr_size + 1)'(1);
  localparam logic [addr_size-1:0] PTR_ONE = addr_size'(1);

  dump_state_t          state_q;
  logic [addr_size-1:0] ptr_q;
  logic [addr_size:0]   cnt_q;
  logic [addr_size-1:0] out_addr_q;
  logic [word_size-1:0] out_data_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef DUMP_CHECKSUM_EN
  logic [word_size-1:0] sum_q;
  logic                 chk_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q       <= '0;
      chk_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            ptr_q   <= bus.first_addr;
            // range length wraps modulo depth, so 1..2**addr_size words
            cnt_q   <= {1'b0, bus.last_addr - bus.first_addr} + CNT_ONE;
            busy_q  <= 1'b1;
            state_q <= READ;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= '0;
            chk_q   <= 1'b0;
`endif
          end
        end
        READ: begin
          out_data_q  <= bus.mem_rd_data;
          out_addr_q  <= ptr_q;
          out_valid_q <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          out_last_q  <= 1'b0;
`else
          out_last_q  <= (cnt_q == CNT_ONE);
`endif
          state_q     <= SEND;
        end
        SEND: begin
          if (bus.out_ready) begin
            if (cnt_q > CNT_ONE) begin
              cnt_q       <= cnt_q - CNT_ONE;
              ptr_q       <= ptr_q + PTR_ONE;
              out_valid_q <= 1'b0;
              state_q     <= READ;
`ifdef DUMP_CHECKSUM_EN
              sum_q       <= sum_q + out_data_q;
            end else if (!chk_q) begin
              // last data word just left; replace the beat in place with the sum
              chk_q       <= 1'b1;
              sum_q       <= sum_q + out_data_q;
              out_data_q  <= sum_q + out_data_q;
              out_addr_q  <= '0;
              out_last_q  <= 1'b1;
`endif
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= FIN;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.cpu_hold    = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_rd_addr = ptr_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_addr    = out_addr_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
endmodule

// File: tb/tb_mem_dump_unit.sv
// tb/tb_mem_dump_unit.sv - directed scoreboard bench for mem_dump_unit
module tb_mem_dump_unit;
  import risc_spm_pkg::*;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  logic [7:0] mem [MEM_DEPTH];
  beat_t exp_q[$];

  mem_dump_unit_if #(.word_size(WORD_SIZE), .addr_size(ADDR_SIZE)) bus ();

  mem_dump_unit #(.word_size(WORD_SIZE), .addr_size(ADDR_SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  assign bus.mem_rd_data = mem[bus.mem_rd_addr];

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic void push_dump(input logic [7:0] first, input logic [7:0] last);
    logic [7:0] a;
    logic [7:0] sum;
    int n;
    beat_t b;
    n = int'(8'(last - first)) + 1;
    a = first;
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      b.a = a;
      b.d = mem[a];
      sum = sum + mem[a];
`ifdef DUMP_CHECKSUM_EN
      b.l = 1'b0;
`else
      b.l = (i == n - 1);
`endif
      exp_q.push_back(b);
      a = a + 8'd1;
    end
`ifdef DUMP_CHECKSUM_EN
    b.a = 8'd0;
    b.d = sum;
    b.l = 1'b1;
    exp_q.push_back(b);
`endif
  endfunction

  // Monitor: transfers are decided by values stable at the falling edge.
  logic       stall_q = 1'b0;
  logic       done_prev = 1'b0;
  beat_t      held;
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    if (!rst) begin
      got = '{a: bus.out_addr, d: bus.out_data, l: bus.out_last};
      if (stall_q) begin
        check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_beat", {15'd0, got}, {15'd0, held});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {15'd0, got}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", {15'd0, got}, {15'd0, e});
        end
        xfer_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        check("done_one_cycle", {31'd0, done_prev}, 32'd0);
      end
      stall_q   = bus.out_valid && !bus.out_ready;
      held      = got;
      done_prev = bus.done;
    end else begin
      stall_q   = 1'b0;
      done_prev = 1'b0;
    end
  end

  task automatic run_dump(input logic [7:0] first, input logic [7:0] last, input bit rnd);
    bit seen;
    bit bad;
    seen = 0;
    bad  = 0;
    push_dump(first, last);
    bus.out_ready  = 1'b1;
    bus.first_addr = first;
    bus.last_addr  = last;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.first_addr = 8'hEE;
    bus.last_addr  = 8'hEE;
    check("lat_busy", {31'd0, bus.busy}, 32'd1);
    check("lat_valid0", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid1", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 3000; i++) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (!bus.busy || !bus.cpu_hold) bad = 1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("busy_throughout", {31'd0, bad}, 32'd0);
    check("fin_busy", {30'd0, bus.busy, bus.cpu_hold}, 32'd0);
    check("fin_valid", {30'd0, bus.out_valid, bus.out_last}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_done", {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    int d0;
    bus.start      = 1'b0;
    bus.first_addr = 8'd0;
    bus.last_addr  = 8'd0;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'(i * 7 + 3);
    mem[128] = 8'd1; mem[129] = 8'd2; mem[130] = 8'd3;
    mem[5]   = 8'h96;
    mem[254] = 8'hA0; mem[255] = 8'hB1; mem[0] = 8'hC2; mem[1] = 8'hD3;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {27'd0, bus.busy, bus.done, bus.cpu_hold, bus.out_valid, bus.out_last}, 32'd0);
    check("rst_addr", {16'd0, bus.out_addr, bus.mem_rd_addr}, 32'd0);
    check("rst_data", {24'd0, bus.out_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_dump(8'd128, 8'd130, 0);
    run_dump(8'd5, 8'd5, 0);
    run_dump(8'd254, 8'd1, 0);
    run_dump(8'd0, 8'd14, 1);
    run_dump(8'd1, 8'd0, 0);

    // Reset while the third beat of a 10-word dump is pending.
    d0 = done_cnt;
    push_dump(8'd20, 8'd29);
    bus.first_addr = 8'd20;
    bus.last_addr  = 8'd29;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (xfer_cnt > 0 && bus.out_valid && bus.out_addr == 8'd22) break;
    end
    check("mid_addr", {24'd0, bus.out_addr}, 32'd22);
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_drop", {29'd0, bus.busy, bus.cpu_hold, bus.out_valid}, 32'd0);
    check("rst_rd_addr", {24'd0, bus.mem_rd_addr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("no_done_on_rst", done_cnt, d0);
    run_dump(8'd40, 8'd49, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
